// File: rtl/display_scheduler.sv
// Round-robin time-sharing of a two-digit hex display among N_REQ requesters.
// Each grant latches one 8-bit value and holds it for HOLD_CYCLES clocks.
module display_scheduler #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] dados,
  input  logic               hold,
  output logic [7:0]         saida,
  output logic               valido,
  output logic [N_REQ-1:0]   grant,
  output logic               fim
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [N_REQ-1:0]   grant_n;
  logic [7:0]         saida_n;
  logic               valido_n, fim_n;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W:0]     scan;
  logic               do_switch;

  // First active requester at or after the pointer, wrapping at N_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(N_REQ)) scan = scan - (PTR_W+1)'(N_REQ);
      if (!sel_found && req[scan[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    grant_n   = grant;
    saida_n   = saida;
    valido_n  = valido;
    fim_n     = 1'b0;
    do_switch = 1'b0;

    case (state)
      IDLE: begin
        valido_n  = 1'b0;
        grant_n   = '0;
        do_switch = sel_found;
      end
      SHOW: begin
        // Abort outranks both expiry and hold.
        if ((req & grant) == '0) begin
          do_switch = 1'b1;
        end else if (cnt == LAST_CNT && !hold) begin
          fim_n     = 1'b1;
          do_switch = 1'b1;
        end else if (!hold) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_switch) begin
      if (sel_found) begin
        grant_n          = '0;
        grant_n[sel_idx] = 1'b1;
        saida_n          = dados[{sel_idx, 3'b000} +: 8];
        valido_n         = 1'b1;
        cnt_n            = '0;
        ptr_n            = (sel_idx == PTR_W'(N_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
        state_n          = SHOW;
      end else begin
        grant_n  = '0;
        valido_n = 1'b0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      grant  <= '0;
      saida  <= 8'h00;
      valido <= 1'b0;
      fim    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ptr    <= ptr_n;
      grant  <= grant_n;
      saida  <= saida_n;
      valido <= valido_n;
      fim    <= fim_n;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with N_REQ=4, HOLD_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_display_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] dados;
  logic        hold;
  logic [7:0]  saida;
  logic        valido;
  logic [3:0]  grant;
  logic        fim;

  int checks = 0;
  int errors = 0;

  display_scheduler #(
    .N_REQ(4),
    .HOLD_CYCLES(4),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .dados(dados),
    .hold(hold),
    .saida(saida),
    .valido(valido),
    .grant(grant),
    .fim(fim)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic [7:0] s,
                          input logic v, input logic f);
    checkOutput({tag, " grant"}, 32'(grant), 32'(g));
    checkOutput({tag, " saida"}, 32'(saida), 32'(s));
    checkOutput({tag, " valido"}, 32'(valido), 32'(v));
    checkOutput({tag, " fim"}, 32'(fim), 32'(f));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic h);
    req   = r;
    dados = d;
    hold  = h;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Brief asynchronous reset pulse placed between edges.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rot_grant [4];
    logic [7:0] rot_saida [4];
    rot_grant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rot_saida = '{8'h11, 8'h22, 8'h44, 8'h11};

    rst_n = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b0);

    // Reset takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1 checkAll("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;

    // Single requester, re-granted after each dwell.
    applyStimulus(4'b0100, 32'h00A5_0000, 1'b0);
    step(1);
    checkAll("single grant", 4'b0100, 8'hA5, 1'b1, 1'b0);
    step(3);
    checkAll("single last cycle", 4'b0100, 8'hA5, 1'b1, 1'b0);
    step(1);
    checkAll("single expiry", 4'b0100, 8'hA5, 1'b1, 1'b1);
    step(1);
    checkOutput("single fim one cycle", 32'(fim), 32'd0);
    step(2);
    checkOutput("single restart no fim", 32'(fim), 32'd0);
    step(1);
    checkOutput("single second expiry", 32'(fim), 32'd1);
    applyStimulus(4'b0000, 32'h00A5_0000, 1'b0);
    step(1);
    checkAll("single to idle", 4'b0000, 8'hA5, 1'b0, 1'b0);

    // Rotation over 1011.
    step(1);
    doReset();
    applyStimulus(4'b1011, 32'h4433_2211, 1'b0);
    for (int g = 0; g < 4; g++) begin
      step(1);
      checkAll($sformatf("rot start %0d", g), rot_grant[g], rot_saida[g], 1'b1, (g > 0));
      step(3);
      checkAll($sformatf("rot end %0d", g), rot_grant[g], rot_saida[g], 1'b1, 1'b0);
    end

    // Hold stretches the dwell by three cycles; abort beats hold.
    step(1);
    doReset();
    applyStimulus(4'b0011, 32'h0000_2211, 1'b0);
    step(1);
    checkAll("hold grant", 4'b0001, 8'h11, 1'b1, 1'b0);
    hold = 1'b1;
    step(3);
    hold = 1'b0;
    checkAll("hold frozen", 4'b0001, 8'h11, 1'b1, 1'b0);
    step(3);
    checkAll("hold no early fim", 4'b0001, 8'h11, 1'b1, 1'b0);
    step(1);
    checkAll("hold delayed expiry", 4'b0010, 8'h22, 1'b1, 1'b1);
    applyStimulus(4'b0001, 32'h0000_2211, 1'b1);
    step(1);
    checkAll("abort beats hold", 4'b0001, 8'h11, 1'b1, 1'b0);
    hold = 1'b0;

    // Abort mid-dwell, then drop everything.
    step(1);
    doReset();
    applyStimulus(4'b0011, 32'h0000_2211, 1'b0);
    step(1);
    checkAll("abort grant", 4'b0001, 8'h11, 1'b1, 1'b0);
    step(2);
    req = 4'b0010;
    step(1);
    checkAll("abort switch", 4'b0010, 8'h22, 1'b1, 1'b0);
    req = 4'b0000;
    step(1);
    checkAll("abort idle", 4'b0000, 8'h22, 1'b0, 1'b0);

    // Data freeze, then reset mid-dwell.
    step(1);
    doReset();
    applyStimulus(4'b0001, 32'h0000_005A, 1'b0);
    step(1);
    checkAll("freeze grant", 4'b0001, 8'h5A, 1'b1, 1'b0);
    dados = 32'h0000_77C3;
    step(1);
    checkAll("freeze held", 4'b0001, 8'h5A, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1 checkAll("mid reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    req   = 4'b0010;
    rst_n = 1'b1;
    step(1);
    checkAll("post reset grant", 4'b0010, 8'h77, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
